ws2812_rx: RTL and testbench



---
 rtl/ws2812_rx.sv | 176 +++++++++++++++++
 tb/tb_ws2812_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812 single-wire NRZ receiver: decodes pulse widths into pixels, detects the
// latch low time, and forwards everything after the first LED_CNT pixels on dout.
module ws2812_rx #(
    parameter int CLK_SPEED     = 25_000_000,
    parameter int LED_CNT       = 1,
    parameter int CHANNELS      = 3,
    parameter int BITPERCHANNEL = 8,
    parameter int HIGH0_NS      = 400,
    parameter int HIGH1_NS      = 800,
    parameter int PERIOD_NS     = 1250,
    parameter int REFRESH_NS    = 50000
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic                                           din,
    output logic                                           dout,
    output logic [CHANNELS*BITPERCHANNEL-1:0]              pixel_o,
    output logic [((LED_CNT > 1) ? $clog2(LED_CNT) : 1)-1:0] pixel_idx,
    output logic                                           pixel_valid,
    output logic                                           frame_done,
    output logic                                           err
);

    function automatic int ns_to_cyc(input int ns);
        return int'((longint'(CLK_SPEED / 1000) * longint'(ns)) / 64'sd1_000_000);
    endfunction

    localparam int W           = CHANNELS * BITPERCHANNEL;
    localparam int IDX_W       = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;
    localparam int THRESH      = ns_to_cyc((HIGH0_NS + HIGH1_NS) / 2);
    localparam int MIN_HIGH    = ns_to_cyc(HIGH0_NS / 2);
    localparam int MAX_HIGH    = ns_to_cyc(PERIOD_NS);
    localparam int REFRESH_CYC = ns_to_cyc(REFRESH_NS);
    localparam int CNT_W       = $clog2(REFRESH_CYC + 1);
    localparam int BIT_W       = $clog2(W + 1);
    localparam int PIX_W       = $clog2(LED_CNT + 1);

    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] REFRESH_C = CNT_W'(REFRESH_CYC);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state;
    logic             din_p0, din_p1, din_p2;
    logic             din_s, rise, fall;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [BIT_W-1:0] bit_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [W-1:0]     pixel_sr, shifted;
    logic             pass, got_bit, bit_val, last_bit;
    logic             viol, latch, bit_done;

    assign din_s    = din_p1;
    assign rise     = din_s & ~din_p2;
    assign fall     = ~din_s & din_p2;
    assign cnt_inc  = sat_inc(cnt);
    assign bit_val  = (cnt >= THRESH_C);
    assign shifted  = {bit_val, pixel_sr[W-1:1]};
    assign last_bit = (bit_cnt == BIT_W'(W - 1));

    // In HIGH, cnt is the running high time; in LOW/SYNC it is the running low time.
    always_comb begin
        viol     = 1'b0;
        latch    = 1'b0;
        bit_done = 1'b0;
        if (state == HIGH) begin
            viol     = fall ? (cnt < MIN_C) : (cnt_inc >= MAX_C);
            bit_done = fall && (cnt >= MIN_C);
        end
        if (state == LOW)
            latch = !rise && (cnt_inc >= REFRESH_C);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_p0      <= 1'b0;
            din_p1      <= 1'b0;
            din_p2      <= 1'b0;
            state       <= SYNC;
            cnt         <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            pixel_sr    <= '0;
            pass        <= 1'b0;
            got_bit     <= 1'b0;
            dout        <= 1'b0;
            pixel_o     <= '0;
            pixel_idx   <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            din_p0      <= din;
            din_p1      <= din_p0;
            din_p2      <= din_p1;
            dout        <= pass & din_s;
            pixel_valid <= 1'b0;
            frame_done  <= latch && got_bit;
            err         <= viol || (latch && (bit_cnt != '0));

            case (state)
                SYNC: begin
                    if (din_s)
                        cnt <= '0;
                    else if (cnt_inc >= REFRESH_C) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else
                        cnt <= cnt_inc;
                end
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (viol) begin
                        state <= SYNC;
                        cnt   <= '0;
                    end else if (bit_done) begin
                        state <= LOW;
                        cnt   <= CNT_W'(1);
                    end else
                        cnt <= cnt_inc;
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CNT_W'(1);
                    end else if (latch) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else
                        cnt <= cnt_inc;
                end
                default: state <= SYNC;
            endcase

            // Once pass is set the chain owns the bits; we only note that traffic arrived.
            if (bit_done) begin
                got_bit <= 1'b1;
                if (!pass) begin
                    if (last_bit) begin
                        pixel_o     <= shifted;
                        pixel_idx   <= IDX_W'(pix_cnt);
                        pixel_valid <= 1'b1;
                        pixel_sr    <= '0;
                        bit_cnt     <= '0;
                        pix_cnt     <= pix_cnt + PIX_W'(1);
                        if (pix_cnt == PIX_W'(LED_CNT - 1))
                            pass <= 1'b1;
                    end else begin
                        pixel_sr <= shifted;
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                    end
                end
            end

            if (viol || latch) begin
                bit_cnt  <= '0;
                pix_cnt  <= '0;
                pass     <= 1'b0;
                got_bit  <= 1'b0;
                pixel_sr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: randomized pulse trains, a pulse-level reference model
// feeding an event scoreboard, and a cycle-level check of the daisy-chain output.
module tb_ws2812_rx;

    localparam int KHZ      = 25_000_000 / 1000;
    localparam int THRESH   = KHZ * ((400 + 800) / 2) / 1_000_000;
    localparam int MIN_HIGH = KHZ * (400 / 2) / 1_000_000;
    localparam int MAX_HIGH = KHZ * 1250 / 1_000_000;
    localparam int GAP      = 1300;
    localparam int LED_CNT  = 1;
    localparam int W        = 24;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          din = 1'b0;
    logic          dout, pixel_valid, frame_done, err;
    logic [W-1:0]  pixel_o;
    logic [0:0]    pixel_idx;

    ws2812_rx #(.LED_CNT(LED_CNT)) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .dout(dout),
        .pixel_o(pixel_o), .pixel_idx(pixel_idx), .pixel_valid(pixel_valid),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         pv;
        logic         fd;
        logic         er;
        logic [W-1:0] px;
        int           idx;
    } ev_t;

    ev_t      exp_q[$];
    int       total = 0;
    int       bad = 0;
    logic     fwd_cur = 1'b0;
    logic [2:0] dexp = 3'b000;
    int       hw[$];
    logic     fw[$];

    task automatic push_ev(input logic pv, input logic fd, input logic er,
                           input logic [W-1:0] px, input int idx);
        ev_t e;
        e.pv = pv; e.fd = fd; e.er = er; e.px = px; e.idx = idx;
        exp_q.push_back(e);
    endtask

    // Precondition and postcondition: 2 time units after a rising clock edge.
    task automatic hold(input logic v, input logic f, input int n);
        din = v;
        fwd_cur = f;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if ({pixel_o, pixel_idx, pixel_valid, frame_done, err, dout} != '0) begin
            bad++;
            $display("FAIL async_reset got px=%h idx=%0d pv=%b fd=%b err=%b dout=%b want all zero",
                     pixel_o, pixel_idx, pixel_valid, frame_done, err, dout);
        end
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // Model: walks the pulse list, predicts events and which pulses reach dout, then drives.
    task automatic run_frame(input int rst_at);
        int           bits = 0;
        int           npix = 0;
        logic [W-1:0] acc = '0;
        bit           abort = 0;
        bit           any = 0;
        fw.delete();
        foreach (hw[i]) begin
            if (i == rst_at) abort = 1;
            fw.push_back(!abort && (npix >= LED_CNT));
            if (abort) continue;
            if (hw[i] < MIN_HIGH || hw[i] >= MAX_HIGH) begin
                push_ev(1'b0, 1'b0, 1'b1, '0, 0);
                abort = 1;
                continue;
            end
            any = 1;
            if (npix < LED_CNT) begin
                acc[bits] = (hw[i] >= THRESH);
                bits++;
                if (bits == W) begin
                    push_ev(1'b1, 1'b0, 1'b0, acc, npix);
                    npix++;
                    bits = 0;
                    acc = '0;
                end
            end
        end
        if (!abort && any) push_ev(1'b0, 1'b1, bits != 0, '0, 0);
        foreach (hw[i]) begin
            if (i == rst_at) do_reset();
            hold(1'b1, fw[i], hw[i]);
            hold(1'b0, 1'b0, (hw[i] < 27) ? 31 - hw[i] : 4);
        end
        hold(1'b0, 1'b0, GAP);
    endtask

    task automatic rand_bits(input int n);
        hw.delete();
        for (int i = 0; i < n; i++) hw.push_back(int'($urandom_range(MIN_HIGH, MAX_HIGH - 1)));
    endtask

    // Monitor: pops one expectation per strobe cycle; dout compared against din delayed 3 cycles.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (pixel_valid || frame_done || err) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_event t=%0t pv=%b fd=%b err=%b px=%h",
                                 $time, pixel_valid, frame_done, err, pixel_o);
                    end else begin
                        e = exp_q.pop_front();
                        if ({pixel_valid, frame_done, err} != {e.pv, e.fd, e.er} ||
                            (e.pv && (pixel_o != e.px || int'(pixel_idx) != e.idx))) begin
                            bad++;
                            $display("FAIL event t=%0t got pv=%b fd=%b err=%b px=%h idx=%0d want pv=%b fd=%b err=%b px=%h idx=%0d",
                                     $time, pixel_valid, frame_done, err, pixel_o, pixel_idx,
                                     e.pv, e.fd, e.er, e.px, e.idx);
                        end
                    end
                end
                total++;
                if (dout !== dexp[2]) begin
                    bad++;
                    $display("FAIL dout t=%0t got=%b want=%b", $time, dout, dexp[2]);
                end
            end
            dexp = {dexp[1:0], din & fwd_cur};
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({pixel_o, pixel_idx, pixel_valid, frame_done, err, dout} != '0) begin
            bad++;
            $display("FAIL reset_state got px=%h idx=%0d pv=%b fd=%b err=%b dout=%b want all zero",
                     pixel_o, pixel_idx, pixel_valid, frame_done, err, dout);
        end
        reset_n = 1'b1;
        hold(1'b0, 1'b0, GAP);

        // 24'h111111: every fourth bit set
        hw.delete();
        for (int i = 0; i < W; i++) hw.push_back((i % 4 == 0) ? 20 : 10);
        run_frame(-1);

        // all-ones pixel, then an all-zero pixel that must appear on dout
        hw.delete();
        for (int i = 0; i < W; i++) hw.push_back(20);
        for (int i = 0; i < W; i++) hw.push_back(10);
        run_frame(-1);

        // asynchronous reset in the middle of the first pixel
        rand_bits(W);
        run_frame(9);

        // partial pixel: frame_done together with err
        rand_bits(10);
        run_frame(-1);

        rand_bits(W);
        run_frame(-1);

        // runt pulse mid-pixel
        rand_bits(W);
        hw[10] = 3;
        run_frame(-1);

        rand_bits(W + 8);
        run_frame(-1);

        // stuck high
        hw.delete();
        hw.push_back(40);
        run_frame(-1);

        // threshold and width limits
        rand_bits(W);
        hw[0] = THRESH - 1;
        hw[1] = THRESH;
        hw[2] = MIN_HIGH;
        hw[3] = MAX_HIGH - 1;
        run_frame(-1);

        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 56));
            rand_bits(n);
            if ($urandom_range(0, 3) == 0) hw[$urandom_range(0, n - 1)] = int'($urandom_range(1, MIN_HIGH - 1));
            run_frame(-1);
        end

        repeat (20) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events got_left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
